// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared cell encodings, FSM states and line geometry
package board_pkg;

    localparam logic [1:0] ST_ONGOING = 2'b00;
    localparam logic [1:0] ST_P1      = 2'b01;
    localparam logic [1:0] ST_P2      = 2'b10;
    localparam logic [1:0] ST_DRAW    = 2'b11;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_SCAN   = 2'd1,
        FSM_FINISH = 2'd2
    } fsm_state_t;

    // Rows first, then columns, then main diagonal, then anti-diagonal.
    function automatic int line_cell(input int n, input int line, input int k);
        if (line < n)
            return line * n + k;
        if (line < 2 * n)
            return k * n + (line - n);
        if (line == 2 * n)
            return k * n + k;
        return k * n + (n - 1 - k);
    endfunction

endpackage

// File: rtl/board_line_eval.sv
// rtl/board_line_eval.sv - combinational win/liveness check of one board line
module board_line_eval #(
    parameter int N = 3
) (
    input  logic [2*N-1:0] cells,
    output logic           p1_full,
    output logic           p2_full,
    output logic           live
);
    import board_pkg::*;

    logic no_p2_bits;
    logic no_p1_bits;

    // A cell holding a draw (11) kills the line for both players.
    always_comb begin
        p1_full    = 1'b1;
        p2_full    = 1'b1;
        no_p2_bits = 1'b1;
        no_p1_bits = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (cells[2*k +: 2] != ST_P1)
                p1_full = 1'b0;
            if (cells[2*k +: 2] != ST_P2)
                p2_full = 1'b0;
            if (cells[2*k + 1])
                no_p2_bits = 1'b0;
            if (cells[2*k])
                no_p1_bits = 1'b0;
        end
        live = no_p2_bits | no_p1_bits;
    end

endmodule

// File: rtl/board_state_tracker.sv
// rtl/board_state_tracker.sv - macro-board cell store with sequential line scan
module board_state_tracker #(
    parameter int N          = 3,
    parameter int EARLY_DRAW = 0,
    parameter int AW         = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data,
    output logic          busy,
    output logic          valid,
    output logic [1:0]    state_final
);
    import board_pkg::*;

    localparam int CELLS = N * N;
    localparam int L     = 2 * N + 2;
    localparam int LW    = $clog2(L);
    localparam int CW    = $clog2(CELLS + 1);

    logic [1:0]      cells [CELLS];
    fsm_state_t      state, state_nxt;
    logic [LW-1:0]   idx;
    logic            p1_acc, p2_acc, live_acc;
    logic [CW-1:0]   occ;
    logic            wr_ok, finish_fire, last_line;
    logic [1:0]      old_cell, rd_mux;
    logic [2*N-1:0]  line_cells;
    logic            line_p1, line_p2, line_live;

    assign wr_ok       = we && !clear && (32'(addr) < 32'(CELLS));
    assign last_line   = (32'(idx) == 32'(L - 1));
    assign finish_fire = (state == FSM_FINISH) && !wr_ok && !clear;
    assign busy        = (state != FSM_IDLE);

    always_comb begin
        old_cell = ST_ONGOING;
        rd_mux   = ST_ONGOING;
        for (int i = 0; i < CELLS; i++) begin
            if (32'(addr) == 32'(i))
                old_cell = cells[i];
            if (32'(rd_addr) == 32'(i))
                rd_mux = cells[i];
        end
    end

    always_comb begin
        line_cells = '0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < CELLS; i++)
                if (line_cell(N, 32'(idx), k) == i)
                    line_cells[2*k +: 2] = cells[i];
    end

    board_line_eval #(.N(N)) u_line_eval (
        .cells   (line_cells),
        .p1_full (line_p1),
        .p2_full (line_p2),
        .live    (line_live)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++)
                cells[i] <= ST_ONGOING;
            occ <= '0;
        end else if (clear) begin
            for (int i = 0; i < CELLS; i++)
                cells[i] <= ST_ONGOING;
            occ <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < CELLS; i++)
                if (32'(addr) == 32'(i))
                    cells[i] <= data;
            if (old_cell == ST_ONGOING && data != ST_ONGOING)
                occ <= occ + CW'(1);
            else if (old_cell != ST_ONGOING && data == ST_ONGOING)
                occ <= occ - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data <= ST_ONGOING;
        else
            rd_data <= rd_mux;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= FSM_IDLE;
        else
            state <= state_nxt;
    end

    // Any accepted write, even mid-scan, restarts the scan from line 0.
    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = FSM_IDLE;
        else if (wr_ok)
            state_nxt = FSM_SCAN;
        else begin
            case (state)
                FSM_SCAN:   if (last_line) state_nxt = FSM_FINISH;
                FSM_FINISH: state_nxt = FSM_IDLE;
                default:    state_nxt = FSM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            p1_acc   <= 1'b0;
            p2_acc   <= 1'b0;
            live_acc <= 1'b0;
        end else if (clear || wr_ok) begin
            idx      <= '0;
            p1_acc   <= 1'b0;
            p2_acc   <= 1'b0;
            live_acc <= 1'b0;
        end else if (state == FSM_SCAN) begin
            p1_acc   <= p1_acc | line_p1;
            p2_acc   <= p2_acc | line_p2;
            live_acc <= live_acc | line_live;
            idx      <= last_line ? '0 : idx + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_final <= ST_ONGOING;
            valid       <= 1'b0;
        end else if (clear) begin
            state_final <= ST_ONGOING;
            valid       <= 1'b0;
        end else begin
            valid <= finish_fire;
            if (finish_fire) begin
                if (p1_acc || p2_acc)
                    state_final <= {p2_acc, p1_acc};
                else if (32'(occ) == 32'(CELLS) || (EARLY_DRAW != 0 && !live_acc))
                    state_final <= ST_DRAW;
                else
                    state_final <= ST_ONGOING;
            end
        end
    end

endmodule

// File: tb/tb_board_state_tracker.sv
// tb/tb_board_state_tracker.sv - directed and random checks of board_state_tracker
module tb_board_state_tracker;

    logic       clk = 1'b0;
    logic       reset_n, clear, we;
    logic [5:0] addr, rd_addr;
    logic [1:0] data;
    logic [1:0] rd0, rd1, sf0, sf1;
    logic       busy0, busy1, v0, v1;

    always #5 clk = ~clk;

    board_state_tracker #(.N(3), .EARLY_DRAW(0), .AW(6)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .addr(addr), .data(data),
        .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .valid(v0), .state_final(sf0)
    );

    board_state_tracker #(.N(3), .EARLY_DRAW(1), .AW(6)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .addr(addr), .data(data),
        .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .valid(v1), .state_final(sf1)
    );

    int         m_cells [9];
    int         cd;
    logic [1:0] e_sf0, e_sf1, e_rd;
    logic       e_valid;
    int         n_assert = 0;
    int         n_fail   = 0;

    function automatic logic [1:0] game_result(input bit early);
        bit p1 = 0, p2 = 0, any_live = 0;
        int occ = 0;
        int ln [3];
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < 3; k++) begin
                if (l < 3)       ln[k] = m_cells[l*3 + k];
                else if (l < 6)  ln[k] = m_cells[k*3 + (l-3)];
                else if (l == 6) ln[k] = m_cells[k*4];
                else             ln[k] = m_cells[k*2 + 2];
            end
            if (ln[0] == 1 && ln[1] == 1 && ln[2] == 1) p1 = 1;
            if (ln[0] == 2 && ln[1] == 2 && ln[2] == 2) p2 = 1;
            if ((ln[0] <= 1 && ln[1] <= 1 && ln[2] <= 1) ||
                ((ln[0] == 0 || ln[0] == 2) && (ln[1] == 0 || ln[1] == 2) && (ln[2] == 0 || ln[2] == 2)))
                any_live = 1;
        end
        for (int i = 0; i < 9; i++)
            if (m_cells[i] != 0) occ++;
        if (p1 || p2)
            return {p2, p1};
        if (occ == 9 || (early && !any_live))
            return 2'b11;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_data_e0", rd0, e_rd);
        chk("rd_data_e1", rd1, e_rd);
        chk("valid_e0", {1'b0, v0}, {1'b0, e_valid});
        chk("valid_e1", {1'b0, v1}, {1'b0, e_valid});
        chk("state_final_e0", sf0, e_sf0);
        chk("state_final_e1", sf1, e_sf1);
        chk("busy_e0", {1'b0, busy0}, {1'b0, cd > 0});
        chk("busy_e1", {1'b0, busy1}, {1'b0, cd > 0});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        cd = 0; e_sf0 = 2'b00; e_sf1 = 2'b00; e_valid = 1'b0; e_rd = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        e_rd = (int'(rd_addr) < 9) ? 2'(m_cells[int'(rd_addr)]) : 2'b00;
        if (clear) begin
            for (int i = 0; i < 9; i++) m_cells[i] = 0;
            cd = 0; e_sf0 = 2'b00; e_sf1 = 2'b00; e_valid = 1'b0;
        end else if (we && int'(addr) < 9) begin
            m_cells[int'(addr)] = int'(data);
            cd = 9;
            e_valid = 1'b0;
        end else if (cd > 0) begin
            cd--;
            e_valid = (cd == 0);
            if (cd == 0) begin
                e_sf0 = game_result(1'b0);
                e_sf1 = game_result(1'b1);
            end
        end else
            e_valid = 1'b0;
        #1;
        check_all();
    endtask

    task automatic write_cell(input int a, input int d);
        we = 1'b1; addr = 6'(a); data = 2'(d);
        tick();
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1; we = 1'b1; addr = 6'd4; data = 2'b01;
        tick();
        clear = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        reset_n = 1'b1;
    endtask

    int fill_seq [9] = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
    int ed_addr  [8] = '{0, 1, 3, 4, 8, 5, 2, 7};
    int ed_data  [8] = '{1, 2, 2, 1, 3, 1, 2, 2};

    initial begin
        reset_n = 1'b0; clear = 1'b0; we = 1'b0; addr = '0; data = '0; rd_addr = '0;
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;

        // Row 0 for player 1, writes back to back
        write_cell(0, 1); write_cell(1, 1); write_cell(2, 1);
        idle(12);

        do_clear();
        write_cell(2, 2); write_cell(4, 2); write_cell(6, 2);
        idle(11);
        do_clear();
        write_cell(0, 2); write_cell(3, 2); write_cell(6, 2);
        idle(11);

        // Full board with no winner: 8 cells then the 9th
        do_clear();
        for (int i = 0; i < 8; i++) write_cell(i, fill_seq[i]);
        idle(10);
        write_cell(8, fill_seq[8]);
        idle(10);
        for (int i = 0; i < 12; i++) begin
            rd_addr = 6'(i);
            tick();
        end

        do_clear();
        for (int i = 0; i < 8; i++) write_cell(ed_addr[i], ed_data[i]);
        idle(10);

        // Restarted scan: single pulse after the second write
        do_clear();
        write_cell(0, 1);
        idle(3);
        write_cell(1, 1);
        idle(12);
        write_cell(20, 2);
        idle(3);

        write_cell(2, 1);
        idle(4);
        do_reset();
        idle(12);
        write_cell(4, 2);
        idle(4);
        do_clear();
        rd_addr = 6'd0;
        idle(12);

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rd_addr = 6'($urandom_range(0, 11));
            if (r < 2)
                do_clear();
            else if (r < 4) begin
                do_reset();
                tick();
            end else if (r < 34)
                write_cell(int'($urandom_range(0, 10)), int'($urandom_range(0, 99) < 45 ? 1 :
                                                           ($urandom_range(0, 99) < 85 ? 2 : int'($urandom_range(0, 3)))));
            else if (r < 92)
                tick();
            else
                idle(10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/board_state_tracker.md
Name: board_state_tracker

Overview:
- Parametrised macro-board state tracker for N×N tic-tac-toe boards.
- Stores one 2-bit state per cell: 00 in progress, 01 player 1 won, 10 player 2 won, 11 draw.
- After any write, a sequential scan evaluates every winning line, one line per cycle, and publishes the final game result with a valid pulse.
- Sits between the micro-board resolvers, which are the writers, and the top-level game FSM and display, which are the readers.

Parameters:
- N, default 3: board side; must be 3..8.
- EARLY_DRAW, default 0: 1 = declare a draw as soon as no line can still be won; 0 = declare a draw only when the board is full.
- AW, default 6: address width; AW ≥ clog2(N*N).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of the whole board
- we  in  1  write enable
- addr  in  AW  write cell index, r*N+c
- data  in  2  cell state to write
- rd_addr  in  AW  read cell index
- rd_data  out  2  registered cell state at rd_addr
- busy  out  1  scan in progress
- valid  out  1  one-cycle pulse: state_final just updated
- state_final  out  2  00 in progress, 01 P1 won, 10 P2 won, 11 draw

Behaviour:
- Reset values (async, reset_n=0): all cells 00; rd_data 00; state_final 00; valid 0; busy 0; occupied counter 0; FSM IDLE; line index 0.
- Constants: L = 2N+2 lines.
  - Lines 0..N-1: rows.
  - Lines N..2N-1: columns.
  - Line 2N: main diagonal (r=c).
  - Line 2N+1: anti-diagonal (c=N-1-r).
- Write:
  - Cell is updated at the edge where we=1, clear=0 and addr<N*N.
  - Writes with addr≥N*N are ignored entirely, including the scan trigger.
- Occupied counter, updated on each accepted write:
  - +1 on a 00→non-00 transition.
  - -1 on a non-00→00 transition.
  - Otherwise unchanged.
- Read: rd_data <= cell[rd_addr] every edge; rd_data <= 00 if rd_addr≥N*N. Latency 1 cycle.
- FSM states: IDLE, SCAN, FINISH.
  - IDLE→SCAN on an accepted write; line index 0; accumulators cleared.
  - SCAN: each cycle evaluates line[idx] over its N cells and ORs the results into the accumulators.
    - p1_acc: all cells of the line are 01.
    - p2_acc: all cells of the line are 10.
    - live_acc: every cell of the line is in {00,01}, or every cell is in {00,10}.
  - SCAN, idx=L-1 → FINISH.
  - FINISH → IDLE. At this edge:
    - state_final <= {p2_acc, p1_acc} if either accumulator is set.
    - Else 11 if occupied==N*N, or if (EARLY_DRAW && !live_acc).
    - Else 00.
    - valid <= 1 for exactly one cycle.
- Latency: write accepted at edge t → state_final and valid change at edge t+L+1. For N=3 this is 9 cycles.
- busy = 1 while the FSM is in SCAN or FINISH.
- Write during SCAN/FINISH: the cell is updated, the scan restarts at idx 0 with accumulators cleared, no valid pulse is issued for the aborted scan, and state_final holds its old value.
- Both players holding a line (illegal but possible): state_final = 11.
- clear:
  - Has priority over we.
  - All cells 00, counter 0, state_final 00, valid 0, FSM IDLE.
  - Does not start a scan.
- reset_n asserted mid-scan: immediate return to reset values; no valid pulse.
- state_final is held between scans; it is never combinational from the cells.

Decomposition:
- Shared package board_pkg:
  - Cell encodings ST_ONGOING=2'b00, ST_P1=2'b01, ST_P2=2'b10, ST_DRAW=2'b11.
  - FSM state encoding.
  - Function line_cell(n, line, k) returning the flat index of the k-th cell of a line.
- One sub-module, board_line_eval (combinational):
  - Takes N 2-bit cells.
  - Returns p1_full, p2_full, live.

Test Plan (N=3 unless stated):
- Write 01 to cells 0,1,2 (back-to-back) → busy high; valid pulses 9 cycles after the last write; state_final=01.
- Write 10 to cells 2,4,6 (anti-diagonal) → state_final=10; writing 10 to cells 0,3,6 instead (column) → also 10.
- Fill the board 01,10,01 / 01,10,10 / 10,01,01 with EARLY_DRAW=0 → occupied=9, state_final=11; with 8 cells filled → 00.
- EARLY_DRAW=1: write 01@0, 10@1, 10@3, 01@4, 11@8, 01@5, 10@2, 10@7 → no live line, state_final=11 with 1 cell still 00.
- Write 01@0, then 01@1 four cycles later → exactly one valid pulse, 9 cycles after the second write; state_final unchanged until then.
- Mid-scan reset_n pulse or clear → state_final=00, valid never pulses, busy=0; rd_addr=0 then reads 00.
